// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word requests
// and buffers returned instructions in a DEPTH-entry queue for decode.
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [31:0]     inst_data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_data  [DEPTH];
    logic [XLEN-1:0] tag_mem [DEPTH];
    logic [CW-1:0]   wr_ptr, rd_ptr, inflight, drop, count;
    logic [AW-1:0]   tag_wr, tag_rd;
    logic [CW:0]     credit_used;
    logic            req_fire, rsp_discard, push, pop, empty;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign credit_used = {1'b0, count} + {1'b0, inflight};

    // Every accepted request already owns a queue slot, so responses never need back-pressure.
    assign imem_req_valid_o = rst_n && !redirect_i && (credit_used < DEPTH_C);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign rsp_discard = redirect_i || (drop != '0);
    assign push        = imem_rsp_valid_i && !rsp_discard;
    assign pop         = !empty && inst_ready_i && !redirect_i;

    assign inst_valid_o = !empty;
    assign inst_pc_o    = empty ? '0 : q_pc[rd_ptr[AW-1:0]];
    assign inst_data_o  = empty ? '0 : q_data[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            drop     <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
        end else begin
            if (redirect_i)
                pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
            else if (req_fire)
                pc_q <= pc_q + XLEN'(4);

            // Tags track memory order, so they advance on every response, dropped or not.
            if (req_fire)
                tag_wr <= tag_wr + 1'b1;
            if (imem_rsp_valid_i)
                tag_rd <= tag_rd + 1'b1;

            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid_i);

            if (redirect_i)
                drop <= inflight - CW'(imem_rsp_valid_i);
            else if (imem_rsp_valid_i && (drop != '0))
                drop <= drop - 1'b1;

            if (redirect_i) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; the outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_mem[tag_wr] <= pc_q;
        if (push) begin
            q_pc[wr_ptr[AW-1:0]]   <= tag_mem[tag_rd];
            q_data[wr_ptr[AW-1:0]] <= imem_rsp_data_i;
        end
    end

endmodule
